// File: rtl/rf_load_sequencer_pkg.sv
// Shared types for the RF load sequencer: source codes seen by the decoder and
// writeback mux, plus the sequencer state encoding.
package rf_load_sequencer_pkg;

  typedef enum logic [1:0] {
    SRC_RF      = 2'b00,
    SRC_MEM     = 2'b01,
    SRC_IMM     = 2'b10,
    SRC_ILLEGAL = 2'b11
  } src_e;

  typedef logic [2:0] seq_state_e;

  localparam seq_state_e IDLE     = 3'd0;
  localparam seq_state_e RF_RD    = 3'd1;
  localparam seq_state_e MEM_WAIT = 3'd2;
  localparam seq_state_e WRITE    = 3'd3;
  localparam seq_state_e ERROR    = 3'd4;

endpackage

// File: rtl/rf_load_sequencer_timeout_counter.sv
// Saturating MEM_WAIT cycle counter; expired flags the last permitted wait cycle.
module rf_load_sequencer_timeout_counter #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_W'(MEM_TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The wait cycle that would bring the count to MEM_TIMEOUT is the final one.
  assign expired = enable && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/rf_load_sequencer.sv
// Multi-cycle RF load/move sequencer driving the rf/mem/imm writeback mux.
// Every output is a flop loaded from the next-state decode.
module rf_load_sequencer
  import rf_load_sequencer_pkg::*;
#(
  parameter int RF_ADDR_WIDTH   = 3,
  parameter int MEM_ADDR_WIDTH  = 8,
  parameter int MUX_SELECT_BITS = 2,
  parameter int MEM_TIMEOUT     = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_src,
  input  logic [MEM_ADDR_WIDTH-1:0]  cmd_src_addr,
  input  logic [RF_ADDR_WIDTH-1:0]   cmd_dst_addr,
  output logic [MUX_SELECT_BITS-1:0] mux_select,
  output logic [RF_ADDR_WIDTH-1:0]   rf_rd_addr,
  output logic [RF_ADDR_WIDTH-1:0]   rf_wr_addr,
  output logic                       rf_we,
  output logic                       mem_req,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  input  logic                       mem_ack,
  output logic                       done,
  output logic                       err
);

  seq_state_e                 state_q, state_d;
  logic [1:0]                 src_q, src_d;
  logic [RF_ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic                       cmd_ready_q, cmd_ready_d;
  logic [MUX_SELECT_BITS-1:0] mux_select_q, mux_select_d;
  logic [RF_ADDR_WIDTH-1:0]   rf_rd_addr_q, rf_rd_addr_d;
  logic [RF_ADDR_WIDTH-1:0]   rf_wr_addr_q, rf_wr_addr_d;
  logic                       rf_we_q, rf_we_d;
  logic                       mem_req_q, mem_req_d;
  logic [MEM_ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic accept;
  logic timeout;

  assign accept = cmd_valid && cmd_ready_q;

  rf_load_sequencer_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (state_q == MEM_WAIT),
    .expired(timeout)
  );

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    mux_select_d = mux_select_q;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_wr_addr_d = rf_wr_addr_q;
    mem_addr_d   = mem_addr_q;
    rf_we_d      = 1'b0;
    mem_req_d    = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d = cmd_src;
          dst_d = cmd_dst_addr;
          case (cmd_src)
            SRC_RF: begin
              state_d      = RF_RD;
              rf_rd_addr_d = cmd_src_addr[RF_ADDR_WIDTH-1:0];
            end
            SRC_MEM: begin
              state_d    = MEM_WAIT;
              mem_addr_d = cmd_src_addr;
              mem_req_d  = 1'b1;
            end
            SRC_IMM: state_d = WRITE;
            default: state_d = ERROR;
          endcase
        end
      end
      RF_RD: state_d = WRITE;
      MEM_WAIT: begin
        // An ack landing on the timeout cycle still completes the command.
        if (mem_ack) begin
          state_d = WRITE;
        end else if (timeout) begin
          state_d = ERROR;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == WRITE) begin
      rf_we_d      = 1'b1;
      done_d       = 1'b1;
      rf_wr_addr_d = dst_d;
      mux_select_d = MUX_SELECT_BITS'(src_d);
    end
    err_d       = (state_d == ERROR);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      cmd_ready_q  <= 1'b1;
      mux_select_q <= '0;
      rf_rd_addr_q <= '0;
      rf_wr_addr_q <= '0;
      rf_we_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      cmd_ready_q  <= cmd_ready_d;
      mux_select_q <= mux_select_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_we_q      <= rf_we_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign mux_select = mux_select_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_we      = rf_we_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
